bcd_converter_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It generalises the team's fixed 8-bit combinational BCD decoder to arbitrary input width and digit count. It adds a start/done handshake, an optional signed (sign-magnitude) mode and overflow detection. It sits between counter/sensor datapaths (e.g. PS/2 mouse position counters) and 7-segment display drivers.

---
 rtl/bcd_converter_seq.sv | 160 ++++++++++++++++
 tb/tb_bcd_converter_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one bit per clock.
// A start/done handshake is provided, along with optional sign-magnitude handling
// for two's complement inputs and a sticky overflow flag.
// The flag is raised when the magnitude does not fit in DIGITS decimal digits.
module bcd_converter_seq #(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 3,
  parameter int SIGNED   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   bin,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  overflow
);

  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam int DW = 4 * DIGITS;
  localparam logic [IN_WIDTH-1:0] ONE = {{(IN_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IN_WIDTH-1:0]  mag_q, mag_d;
  logic [DW-1:0]        digits_q, digits_d;
  logic                 sign_q, sign_d;
  logic                 ovf_q, ovf_d;
  logic [DW-1:0]        bcd_q, bcd_d;
  logic                 neg_q, neg_d;
  logic                 overflow_q, overflow_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [DW-1:0]          adj_digits;
  logic [DW+IN_WIDTH-1:0] shifted;

  // Add 3 to every digit that is 5 or more, so the next shift carries correctly into the digit above
  always_comb begin
    adj_digits = digits_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits_q[4*i +: 4] >= 4'd5) begin
        adj_digits[4*i +: 4] = 4'(digits_q[4*i +: 4] + 4'd3);
      end
    end
    shifted = {adj_digits, mag_q} << 1;
  end

  // Next-state and next-output logic. ready drops while a done pulse is showing,
  // so the first accept after a result lands one cycle after done
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    digits_d   = digits_q;
    sign_d     = sign_q;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    neg_d      = neg_q;
    overflow_d = overflow_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (start && ready_q) begin
          if ((SIGNED != 0) && bin[IN_WIDTH-1]) begin
            mag_d  = ~bin + ONE;
            sign_d = 1'b1;
          end else begin
            mag_d  = bin;
            sign_d = 1'b0;
          end
          cnt_d    = CW'(IN_WIDTH);
          digits_d = '0;
          ovf_d    = 1'b0;
          state_d  = SHIFT;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
        end
      end
      SHIFT: begin
        ready_d  = 1'b0;
        busy_d   = 1'b1;
        {digits_d, mag_d} = shifted;
        ovf_d    = ovf_q | adj_digits[DW-1];
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FINISH;
          busy_d  = 1'b0;
        end
      end
      FINISH: begin
        bcd_d      = digits_q;
        neg_d      = sign_q;
        overflow_d = ovf_q;
        done_d     = 1'b1;
        ready_d    = 1'b0;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // All state and registered outputs; reset aborts any conversion in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mag_q      <= '0;
      digits_q   <= '0;
      sign_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
      overflow_q <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      digits_q   <= digits_d;
      sign_q     <= sign_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
      neg_q      <= neg_d;
      overflow_q <= overflow_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign neg      = neg_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Directed bench for bcd_converter_seq.
// Four instances share one clock: 8-bit/3-digit unsigned, 8-bit/3-digit signed,
// 8-bit/2-digit unsigned (overflow) and 16-bit/5-digit unsigned.
module tb_bcd_converter_seq;

  logic clk = 1'b0;
  logic startV [4];
  logic [15:0] binV [4];
  logic rstN [4];
  logic readyV [4];
  logic busyV [4];
  logic doneV [4];
  logic negV [4];
  logic ovfV [4];
  logic [19:0] bcdV [4];

  logic [11:0] u8Bcd;
  logic [11:0] s8Bcd;
  logic [7:0]  d2Bcd;
  logic [19:0] w16Bcd;

  int checks = 0;
  int errors = 0;

  int latency;
  int busyCycles;
  int doneWidth;
  int waitCycles;
  int busyCnt;
  bit sawDone;

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  bcd_converter_seq #(.IN_WIDTH(8), .DIGITS(3), .SIGNED(0)) u8Dut (
    .clk(clk), .rst_n(rstN[0]), .start(startV[0]), .bin(binV[0][7:0]),
    .ready(readyV[0]), .busy(busyV[0]), .done(doneV[0]), .bcd(u8Bcd),
    .neg(negV[0]), .overflow(ovfV[0]));

  bcd_converter_seq #(.IN_WIDTH(8), .DIGITS(3), .SIGNED(1)) s8Dut (
    .clk(clk), .rst_n(rstN[1]), .start(startV[1]), .bin(binV[1][7:0]),
    .ready(readyV[1]), .busy(busyV[1]), .done(doneV[1]), .bcd(s8Bcd),
    .neg(negV[1]), .overflow(ovfV[1]));

  bcd_converter_seq #(.IN_WIDTH(8), .DIGITS(2), .SIGNED(0)) d2Dut (
    .clk(clk), .rst_n(rstN[2]), .start(startV[2]), .bin(binV[2][7:0]),
    .ready(readyV[2]), .busy(busyV[2]), .done(doneV[2]), .bcd(d2Bcd),
    .neg(negV[2]), .overflow(ovfV[2]));

  bcd_converter_seq #(.IN_WIDTH(16), .DIGITS(5), .SIGNED(0)) w16Dut (
    .clk(clk), .rst_n(rstN[3]), .start(startV[3]), .bin(binV[3]),
    .ready(readyV[3]), .busy(busyV[3]), .done(doneV[3]), .bcd(w16Bcd),
    .neg(negV[3]), .overflow(ovfV[3]));

  assign bcdV[0] = {8'h00, u8Bcd};
  assign bcdV[1] = {8'h00, s8Bcd};
  assign bcdV[2] = {12'h000, d2Bcd};
  assign bcdV[3] = w16Bcd;

  // One comparison: counts it, and on mismatch counts the error and reports it
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Must be called at a negedge. Requests a conversion of value and waits for
  // the accept. bin is then changed to lateValue, and start is dropped unless
  // holdStart is set. Latency counts edges from the accept edge up to the edge
  // that raises done, both included. A value of -1 means a timeout.
  task automatic applyStimulus(input int sel, input logic [15:0] value,
                               input logic [15:0] lateValue, input bit holdStart,
                               output int lat, output int busyN,
                               output int doneW, output int waitN);
    int guard;
    binV[sel]   = value;
    startV[sel] = 1'b1;
    waitN = 0;
    while (!readyV[sel] && waitN < 100) begin
      @(negedge clk);
      waitN++;
    end
    @(posedge clk);
    lat   = 1;
    busyN = 0;
    doneW = 0;
    guard = 0;
    @(negedge clk);
    binV[sel] = lateValue;
    if (!holdStart) startV[sel] = 1'b0;
    while (!doneV[sel] && guard < 100) begin
      if (busyV[sel]) busyN++;
      @(posedge clk);
      lat++;
      @(negedge clk);
      guard++;
    end
    if (!doneV[sel]) begin
      lat = -1;
    end else begin
      doneW = 1;
      @(negedge clk);
      if (doneV[sel]) doneW = 2;
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      startV[i] = 1'b0;
      binV[i]   = 16'h0000;
      rstN[i]   = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Values held while in reset
    checkOutput("rst_ready", 32'(readyV[0]), 32'd1);
    checkOutput("rst_busy", 32'(busyV[0]), 32'd0);
    checkOutput("rst_done", 32'(doneV[0]), 32'd0);
    checkOutput("rst_bcd", 32'(bcdV[0]), 32'h000);
    checkOutput("rst_neg_ovf", {30'd0, negV[1], ovfV[2]}, 32'd0);
    checkOutput("rst_w16_ready", 32'(readyV[3]), 32'd1);

    for (int i = 0; i < 4; i++) rstN[i] = 1'b1;
    @(negedge clk);

    // Unsigned 8-bit, full scale, with latency, busy length and done width
    applyStimulus(0, 16'd255, 16'd17, 1'b0, latency, busyCycles, doneWidth, waitCycles);
    checkOutput("u8_255_latency", 32'(latency), 32'd10);
    checkOutput("u8_255_busy", 32'(busyCycles), 32'd8);
    checkOutput("u8_255_donew", 32'(doneWidth), 32'd1);
    checkOutput("u8_255_bcd", 32'(bcdV[0]), 32'h255);
    checkOutput("u8_255_flags", {30'd0, negV[0], ovfV[0]}, 32'd0);

    applyStimulus(0, 16'd0, 16'd200, 1'b0, latency, busyCycles, doneWidth, waitCycles);
    checkOutput("u8_0_bcd", 32'(bcdV[0]), 32'h000);
    applyStimulus(0, 16'd9, 16'd0, 1'b0, latency, busyCycles, doneWidth, waitCycles);
    checkOutput("u8_9_bcd", 32'(bcdV[0]), 32'h009);
    checkOutput("u8_9_donew", 32'(doneWidth), 32'd1);

    // start held high throughout; bin switches to 37 while the first conversion is busy
    applyStimulus(0, 16'd100, 16'd37, 1'b1, latency, busyCycles, doneWidth, waitCycles);
    checkOutput("hold_100_bcd", 32'(bcdV[0]), 32'h100);
    checkOutput("hold_100_busy", 32'(busyCycles), 32'd8);
    checkOutput("hold_100_latency", 32'(latency), 32'd10);
    applyStimulus(0, 16'd37, 16'd37, 1'b1, latency, busyCycles, doneWidth, waitCycles);
    checkOutput("hold_37_wait", 32'(waitCycles), 32'd0);
    checkOutput("hold_37_bcd", 32'(bcdV[0]), 32'h037);
    startV[0] = 1'b0;

    // Signed mode
    applyStimulus(1, 16'h0080, 16'h0001, 1'b0, latency, busyCycles, doneWidth, waitCycles);
    checkOutput("s8_80_bcd", 32'(bcdV[1]), 32'h128);
    checkOutput("s8_80_neg", 32'(negV[1]), 32'd1);
    applyStimulus(1, 16'h00FF, 16'h0000, 1'b0, latency, busyCycles, doneWidth, waitCycles);
    checkOutput("s8_ff_bcd", 32'(bcdV[1]), 32'h001);
    checkOutput("s8_ff_neg", 32'(negV[1]), 32'd1);
    applyStimulus(1, 16'h007F, 16'h0080, 1'b0, latency, busyCycles, doneWidth, waitCycles);
    checkOutput("s8_7f_bcd", 32'(bcdV[1]), 32'h127);
    checkOutput("s8_7f_neg", 32'(negV[1]), 32'd0);
    checkOutput("s8_7f_ovf", 32'(ovfV[1]), 32'd0);

    // Two digits: overflow, then the flag clears on the next conversion
    applyStimulus(2, 16'd200, 16'd5, 1'b0, latency, busyCycles, doneWidth, waitCycles);
    checkOutput("d2_200_bcd", 32'(bcdV[2]), 32'h00);
    checkOutput("d2_200_ovf", 32'(ovfV[2]), 32'd1);
    applyStimulus(2, 16'd99, 16'd250, 1'b0, latency, busyCycles, doneWidth, waitCycles);
    checkOutput("d2_99_bcd", 32'(bcdV[2]), 32'h99);
    checkOutput("d2_99_ovf", 32'(ovfV[2]), 32'd0);

    // 16-bit, five digits
    applyStimulus(3, 16'd65535, 16'd1, 1'b0, latency, busyCycles, doneWidth, waitCycles);
    checkOutput("w16_65535_bcd", 32'(bcdV[3]), 32'h65535);
    checkOutput("w16_65535_latency", 32'(latency), 32'd18);
    checkOutput("w16_65535_ovf", 32'(ovfV[3]), 32'd0);

    // Reset during busy cycle 7 aborts the conversion without a done pulse
    binV[3]   = 16'd4321;
    startV[3] = 1'b1;
    @(posedge clk);
    busyCnt = 0;
    repeat (7) begin
      @(negedge clk);
      startV[3] = 1'b0;
      if (busyV[3]) busyCnt++;
    end
    checkOutput("abort_busy_before", 32'(busyCnt), 32'd7);
    rstN[3] = 1'b0;
    #1;
    checkOutput("abort_ready", 32'(readyV[3]), 32'd1);
    checkOutput("abort_busy", 32'(busyV[3]), 32'd0);
    checkOutput("abort_done", 32'(doneV[3]), 32'd0);
    checkOutput("abort_bcd", 32'(bcdV[3]), 32'h00000);
    @(negedge clk);
    rstN[3] = 1'b1;
    sawDone = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (doneV[3]) sawDone = 1'b1;
    end
    checkOutput("abort_no_done", 32'(sawDone), 32'd0);
    applyStimulus(3, 16'd12345, 16'd999, 1'b0, latency, busyCycles, doneWidth, waitCycles);
    checkOutput("w16_12345_bcd", 32'(bcdV[3]), 32'h12345);
    checkOutput("w16_12345_busy", 32'(busyCycles), 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
